// File: rtl/writeback_queue.sv
// In-order writeback queue feeding the decode-stage register-file write port.
// Buffers completed entries, extends load data and exports a pending-destination mask.
`timescale 1ns/1ps
module writeback_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_we,
    input  logic [4:0]   in_rd,
    input  logic [1:0]   in_kind,
    input  logic [2:0]   in_funct3,
    input  logic [N-1:0] in_value,
    input  logic         memRsp_valid,
    output logic         memRsp_ready,
    input  logic [N-1:0] memRsp_data,
    output logic         regWrite_D,
    output logic [4:0]   writeAddr_D,
    output logic [N-1:0] writeData3_D,
    output logic [31:0]  pendingMask,
    output logic         rsp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] KIND_LOAD = 2'b10;

    logic         q_we     [DEPTH];
    logic [4:0]   q_rd     [DEPTH];
    logic [1:0]   q_kind   [DEPTH];
    logic [2:0]   q_funct3 [DEPTH];
    logic [N-1:0] q_value  [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic         head_valid;
    logic         head_is_load;
    logic         enq;
    logic         retire;
    logic [N-1:0] result;

    function automatic logic [N-1:0] load_ext(input logic [2:0] f,
                                              input logic [N-1:0] d);
        logic [N-1:0] r;
        case (f)
            3'b000:  r = {{(N-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(N-16){d[15]}}, d[15:0]};
            3'b010:  r = {{(N-32){d[31]}}, d[31:0]};
            3'b100:  r = {{(N-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(N-16){1'b0}}, d[15:0]};
            3'b110:  r = {{(N-32){1'b0}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Ready comes from the registered count only, so a same-cycle retire never frees a full queue.
    assign in_ready     = (count != (AW+1)'(DEPTH));
    assign head_valid   = (count != '0);
    assign head_is_load = head_valid && (q_kind[rd_ptr] == KIND_LOAD);
    assign memRsp_ready = head_is_load;
    assign enq          = in_valid && in_ready;
    assign retire       = head_valid && (!head_is_load || memRsp_valid);

    always_comb begin
        result = q_value[rd_ptr];
        if (head_is_load) begin
            result = load_ext(q_funct3[rd_ptr], memRsp_data);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            q_we[wr_ptr]     <= in_we;
            q_rd[wr_ptr]     <= in_rd;
            q_kind[wr_ptr]   <= in_kind;
            q_funct3[wr_ptr] <= in_funct3;
            q_value[wr_ptr]  <= in_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite_D   <= 1'b0;
            writeAddr_D  <= '0;
            writeData3_D <= '0;
            rsp_error    <= 1'b0;
        end else begin
            regWrite_D <= retire && q_we[rd_ptr] && (q_rd[rd_ptr] != 5'd0);
            if (retire) begin
                writeAddr_D  <= q_rd[rd_ptr];
                writeData3_D <= result;
            end
            if (memRsp_valid && !head_is_load) begin
                rsp_error <= 1'b1;
            end
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        logic [AW-1:0] off;
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (({1'b0, off} < count) && q_we[i]) begin
                pendingMask[q_rd[i]] = 1'b1;
            end
        end
        if (regWrite_D) begin
            pendingMask[writeAddr_D] = 1'b1;
        end
        pendingMask[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue.
`timescale 1ns/1ps
module tb_writeback_queue;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_we;
    logic [4:0]   in_rd;
    logic [1:0]   in_kind;
    logic [2:0]   in_funct3;
    logic [N-1:0] in_value;
    logic         memRsp_valid;
    logic         memRsp_ready;
    logic [N-1:0] memRsp_data;
    logic         regWrite_D;
    logic [4:0]   writeAddr_D;
    logic [N-1:0] writeData3_D;
    logic [31:0]  pendingMask;
    logic         rsp_error;

    int checks   = 0;
    int failures = 0;

    writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_we(in_we),
        .in_rd(in_rd),
        .in_kind(in_kind),
        .in_funct3(in_funct3),
        .in_value(in_value),
        .memRsp_valid(memRsp_valid),
        .memRsp_ready(memRsp_ready),
        .memRsp_data(memRsp_data),
        .regWrite_D(regWrite_D),
        .writeAddr_D(writeAddr_D),
        .writeData3_D(writeData3_D),
        .pendingMask(pendingMask),
        .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic we, input logic [4:0] rd,
                         input logic [1:0] kind, input logic [2:0] f3,
                         input logic [63:0] value);
        in_valid  = 1'b1;
        in_we     = we;
        in_rd     = rd;
        in_kind   = kind;
        in_funct3 = f3;
        in_value  = value;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [63:0] data,
                           input logic [63:0] exp, input string tag);
        offer(1'b1, 5'd7, 2'b10, f3, 64'hBAD);
        memRsp_data = data;
        step();
        in_valid = 1'b0;
        chk({tag, "_ready"}, 64'(memRsp_ready), 64'd1);
        memRsp_valid = 1'b1;
        step();
        memRsp_valid = 1'b0;
        chk({tag, "_we"}, 64'(regWrite_D), 64'd1);
        chk({tag, "_addr"}, 64'(writeAddr_D), 64'd7);
        chk({tag, "_data"}, writeData3_D, exp);
        step();
    endtask

    initial begin
        reset        = 1'b1;
        memRsp_valid = 1'b0;
        memRsp_data  = '0;
        offer(1'b1, 5'd9, 2'b00, 3'b000, 64'hAA);

        // reset with an entry offered
        step();
        step();
        chk("rst_we", 64'(regWrite_D), 64'd0);
        chk("rst_addr", 64'(writeAddr_D), 64'd0);
        chk("rst_data", writeData3_D, 64'd0);
        chk("rst_mask", 64'(pendingMask), 64'd0);
        chk("rst_err", 64'(rsp_error), 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        step();
        chk("rst_noent_we", 64'(regWrite_D), 64'd0);
        chk("rst_noent_mask", 64'(pendingMask), 64'd0);

        // single ALU entry
        offer(1'b1, 5'd5, 2'b00, 3'b000, 64'h1234);
        step();
        in_valid = 1'b0;
        chk("alu_c1_mask", 64'(pendingMask), 64'h20);
        chk("alu_c1_we", 64'(regWrite_D), 64'd0);
        step();
        chk("alu_c2_we", 64'(regWrite_D), 64'd1);
        chk("alu_c2_addr", 64'(writeAddr_D), 64'd5);
        chk("alu_c2_data", writeData3_D, 64'h1234);
        chk("alu_c2_mask", 64'(pendingMask), 64'h20);
        step();
        chk("alu_c3_we", 64'(regWrite_D), 64'd0);
        chk("alu_c3_mask", 64'(pendingMask), 64'd0);
        chk("alu_c3_hold", writeData3_D, 64'h1234);

        // load extension
        do_load(3'b001, 64'h80F0, 64'hFFFF_FFFF_FFFF_80F0, "lh");
        do_load(3'b101, 64'h80F0, 64'h80F0, "lhu");
        do_load(3'b000, 64'h80F0, 64'hFFFF_FFFF_FFFF_FFF0, "lb");
        do_load(3'b100, 64'h80F0, 64'hF0, "lbu");
        do_load(3'b010, 64'h1234_5678_8000_00F0,
                64'hFFFF_FFFF_8000_00F0, "lw");
        do_load(3'b110, 64'h1234_5678_8000_00F0, 64'h8000_00F0, "lwu");
        do_load(3'b011, 64'h1234_5678_8000_00F0,
                64'h1234_5678_8000_00F0, "ld");
        do_load(3'b111, 64'hFEDC_0000_0000_0001,
                64'hFEDC_0000_0000_0001, "f111");

        // ordering behind a stalled load
        offer(1'b1, 5'd3, 2'b10, 3'b011, 64'h0);
        step();
        offer(1'b1, 5'd4, 2'b00, 3'b000, 64'h44);
        step();
        in_valid = 1'b0;
        chk("ord_mask", 64'(pendingMask), 64'h18);
        for (int i = 0; i < 5; i++) begin
            chk("ord_wait_we", 64'(regWrite_D), 64'd0);
            chk("ord_wait_ready", 64'(memRsp_ready), 64'd1);
            step();
        end
        memRsp_valid = 1'b1;
        memRsp_data  = 64'hDEAD;
        step();
        memRsp_valid = 1'b0;
        chk("ord_w1_we", 64'(regWrite_D), 64'd1);
        chk("ord_w1_addr", 64'(writeAddr_D), 64'd3);
        chk("ord_w1_data", writeData3_D, 64'hDEAD);
        step();
        chk("ord_w2_we", 64'(regWrite_D), 64'd1);
        chk("ord_w2_addr", 64'(writeAddr_D), 64'd4);
        chk("ord_w2_data", writeData3_D, 64'h44);
        step();
        chk("ord_done_we", 64'(regWrite_D), 64'd0);
        chk("ord_done_mask", 64'(pendingMask), 64'd0);

        // fill to DEPTH behind a stalled load
        for (int i = 0; i <= DEPTH; i++) begin
            if (i == 0) offer(1'b1, 5'd1, 2'b10, 3'b011, 64'h0);
            else offer(1'b1, 5'(i + 1), 2'b00, 3'b000, 64'(i + 1));
            #1;
            chk("bp_ready", 64'(in_ready), (i < DEPTH) ? 64'd1 : 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_mask", 64'(pendingMask), 64'h1E);
        memRsp_valid = 1'b1;
        memRsp_data  = 64'h5;
        #1;
        chk("bp_full_retire_ready", 64'(in_ready), 64'd0);
        step();
        memRsp_valid = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("bp_drain_we", 64'(regWrite_D), 64'd1);
            chk("bp_drain_addr", 64'(writeAddr_D), 64'(i));
            chk("bp_drain_data", writeData3_D, (i == 1) ? 64'h5 : 64'(i));
            step();
        end
        chk("bp_drain_end", 64'(regWrite_D), 64'd0);

        // back-to-back throughput
        offer(1'b1, 5'd10, 2'b01, 3'b000, 64'h100);
        step();
        offer(1'b1, 5'd11, 2'b00, 3'b000, 64'h101);
        step();
        chk("tp1_addr", 64'(writeAddr_D), 64'd10);
        chk("tp1_we", 64'(regWrite_D), 64'd1);
        chk("tp1_ready", 64'(in_ready), 64'd1);
        offer(1'b1, 5'd12, 2'b11, 3'b000, 64'h102);
        step();
        in_valid = 1'b0;
        chk("tp2_addr", 64'(writeAddr_D), 64'd11);
        chk("tp2_mask", 64'(pendingMask), 64'h1800);
        step();
        chk("tp3_addr", 64'(writeAddr_D), 64'd12);
        chk("tp3_data", writeData3_D, 64'h102);
        step();
        chk("tp_end", 64'(regWrite_D), 64'd0);

        // x0 destination
        offer(1'b1, 5'd0, 2'b00, 3'b000, 64'h99);
        step();
        in_valid = 1'b0;
        chk("x0_mask1", 64'(pendingMask), 64'd0);
        step();
        chk("x0_we", 64'(regWrite_D), 64'd0);
        chk("x0_mask2", 64'(pendingMask), 64'd0);
        chk("x0_data", writeData3_D, 64'h99);
        step();

        // stray response on empty queue
        chk("err_before", 64'(rsp_error), 64'd0);
        memRsp_valid = 1'b1;
        step();
        memRsp_valid = 1'b0;
        chk("err_set", 64'(rsp_error), 64'd1);
        chk("err_no_we", 64'(regWrite_D), 64'd0);
        step();
        step();
        chk("err_sticky", 64'(rsp_error), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("err_clear", 64'(rsp_error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

In-order writeback stage that feeds the register-file write port of the decode stage. It accepts completed instructions from the memory stage through a valid/ready handshake and buffers them in a small FIFO. Load results are collected from the data memory and sign- or zero-extended. Each cycle it retires at most one entry onto the registered write port `regWrite_D` / `writeAddr_D` / `writeData3_D`, and it exports a pending-destination mask so decode can stall on RAW hazards.

## Interface
- `N`, 64: datapath width.
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  memory stage offers an entry.
- `in_ready`  out  1  queue can accept; equals not-full, from registered count only.
- `in_we`  in  1  entry writes a register.
- `in_rd`  in  5  destination register.
- `in_kind`  in  2  00 ALU, 01 PC+4, 10 LOAD, 11 treated as ALU.
- `in_funct3`  in  3  load size/sign; meaningful only for LOAD.
- `in_value`  in  N  result for ALU/PC+4; ignored for LOAD.
- `memRsp_valid`  in  1  load data available.
- `memRsp_ready`  out  1  high when the head entry is a LOAD.
- `memRsp_data`  in  N  load data, right-justified.
- `regWrite_D`  out  1  register write enable (registered).
- `writeAddr_D`  out  5  register write address (registered).
- `writeData3_D`  out  N  register write data (registered).
- `pendingMask`  out  32  bit r set while a write to register r is outstanding.
- `rsp_error`  out  1  sticky protocol-error flag.

## Operation
- **Enqueue.** An entry is enqueued when `in_valid && in_ready`. The stored fields are we, rd, kind, funct3 and value.
- **Head readiness.** The head entry is retirable when:
  - its kind is not LOAD; or
  - its kind is LOAD and `memRsp_valid` is high. That cycle is the handshake, since `memRsp_ready` is high whenever the head is a LOAD.
- **Retire.** At most one entry retires per cycle, always the head. On retire the output registers load:
  - `regWrite_D` = we && rd != 0;
  - `writeAddr_D` = rd;
  - `writeData3_D` = the selected result.
- **Idle.** In a cycle with no retire, `regWrite_D` is 0 the next cycle. `writeAddr_D` and `writeData3_D` hold their values.
- **Load extension by funct3.** Bits are taken from `memRsp_data`:
  - 000: sign-extend [7:0].
  - 001: sign-extend [15:0].
  - 010: sign-extend [31:0].
  - 011: all N bits.
  - 100: zero-extend [7:0].
  - 101: zero-extend [15:0].
  - 110: zero-extend [31:0].
  - 111: treated as 011.
- **x0 writes.** An entry with rd = 0 still occupies a slot and retires in order, but never asserts `regWrite_D`.
- **pendingMask.** Bit r (r != 0) is 1 if either:
  - any queued entry has we && rd == r; or
  - the output register currently holds `regWrite_D` = 1 with `writeAddr_D` = r.
  
  Bit 0 is always 0. The mask is combinational from the queue and output state.
- **rsp_error.** Set when `memRsp_valid` is high while the head is not a LOAD, including when the queue is empty. The response is ignored. The flag clears only on reset.
- **Reset.** Empties the queue and clears all outputs to 0: `regWrite_D`, `writeAddr_D`, `writeData3_D`, `pendingMask`, `rsp_error`. `in_ready` is 1 the cycle after reset deasserts. An entry in mid-handshake during reset is discarded. No write is emitted for it.

## Timing
- **Enqueue to head.** An entry accepted in cycle t can be head, and retire, no earlier than cycle t+1.
- **ALU/PC+4 latency.** Accepted at t into an empty queue, it retires at t+1 and `regWrite_D` is high during t+2.
- **LOAD latency.** A LOAD at head retires in the first cycle with `memRsp_valid` = 1. The write is visible the following cycle. Entries behind it wait, so order is strictly preserved.
- **Simultaneous enqueue and retire.** Both happen in the same cycle and the count is unchanged. When full, `in_ready` is 0 even if a retire occurs that cycle.
- **Throughput.** Sustained one entry per cycle with no LOAD stalls.
- **Pointers.** Read and write pointers wrap modulo DEPTH. Full and empty are distinguished by a count.

## Test plan
- **Reset.** Hold `reset` for 2 cycles with `in_valid` = 1 → all outputs 0 and no entry accepted; `in_ready` = 1 after deassert.
- **ALU entry.** Enqueue ALU rd=5, value=0x1234 at cycle 0 → `pendingMask[5]` = 1 during cycles 1–2. Cycle 2 shows `regWrite_D` = 1, `writeAddr_D` = 5, `writeData3_D` = 0x1234. Cycle 3 shows `regWrite_D` = 0 and `pendingMask[5]` = 0.
- **Load sign/zero extension.** LOAD rd=7 with `memRsp_data` = 0x...0000_80F0:
  - funct3 001 → `writeData3_D` = 0xFFFF_FFFF_FFFF_80F0.
  - funct3 101 → 0x80F0.
  - funct3 000 → 0xFFFF_FFFF_FFFF_FFF0.
- **Ordering and backpressure.** Enqueue LOAD rd=3 then ALU rd=4, and delay `memRsp_valid` 5 cycles → no writes and `memRsp_ready` = 1 throughout. After the response, writes occur to 3 then 4 on consecutive cycles. Enqueueing DEPTH+1 entries drives `in_ready` low exactly at DEPTH.
- **x0 write.** ALU rd=0, we=1 → no `regWrite_D` and `pendingMask` stays 0.
- **Stray response.** `memRsp_valid` with the queue empty → `rsp_error` = 1 and stays 1 until reset.
